fetch_sequencer: RTL

- Sequences the single-cycle core against an instruction memory whose latency varies.
- Fetches the word at the core's pointer over a req/ack handshake and presents it as the core's instruction input.
- Pulses a one-cycle commit enable so the core advances exactly once per fetched instruction.
- Supports run, halt, single-step and a fetch-timeout fault; sits between core and instruction memory.

---
 rtl/fetch_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: fetches each instruction over a req/ack handshake and
// pulses a one-cycle commit enable so the single-cycle core advances once.
// Ports:
//   clk, _reset (sync, active-high)
//   run, halt_req, step_req       : execution control from host
//   pointer_in                    : current instruction pointer from core
//   mem_req, mem_addr             : fetch request to instruction memory
//   mem_ack, mem_data             : fetch response from instruction memory
//   instr_out, core_en            : instruction word and commit pulse to core
//   busy, halted, fault, retired  : status and retired-instruction count
module fetch_sequencer #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               _reset,
    input  logic               run,
    input  logic               halt_req,
    input  logic               step_req,
    input  logic [ADDR_W-1:0]  pointer_in,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_data,
    output logic [INSTR_W-1:0] instr_out,
    output logic               core_en,
    output logic               busy,
    output logic               halted,
    output logic               fault,
    output logic [31:0]        retired
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        EXEC   = 3'd2,
        HALTED = 3'd3,
        FAULT  = 3'd4
    } state_t;

    localparam logic [15:0] TMO = 16'(TIMEOUT);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [31:0]        ret_q, ret_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               halt_q, halt_d;
    logic               step_q, step_d;

    always_ff @(posedge clk) begin
        if (_reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            instr_q <= '0;
            ret_q   <= '0;
            cnt_q   <= '0;
            halt_q  <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
            halt_q  <= halt_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        instr_d  = instr_q;
        ret_d    = ret_q;
        halt_d   = halt_q;
        step_d   = step_q;
        cnt_d    = '0;
        mem_req  = 1'b0;
        mem_addr = addr_q;
        core_en  = 1'b0;

        if (halt_req && state_q != IDLE && state_q != FAULT) begin
            halt_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                mem_req = 1'b1;
                // The counter is zero only in the first fetch cycle; the
                // pointer is taken there because the core updates it on
                // the same edge that leaves EXEC.
                if (cnt_q == '0) begin
                    mem_addr = pointer_in;
                    addr_d   = pointer_in;
                end
                if (mem_ack) begin
                    instr_d = mem_data;
                    state_d = EXEC;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_d == TMO) begin
                        state_d = FAULT;
                    end
                end
            end
            EXEC: begin
                core_en = 1'b1;
                ret_d   = ret_q + 32'd1;
                if (halt_q || halt_req || step_q) begin
                    state_d = HALTED;
                    halt_d  = 1'b0;
                    step_d  = 1'b0;
                end else begin
                    state_d = FETCH;
                end
            end
            HALTED: begin
                if (step_req) begin
                    step_d  = 1'b1;
                    state_d = FETCH;
                end else if (run && !halt_req) begin
                    state_d = FETCH;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign instr_out = instr_q;
    assign retired   = ret_q;
    assign busy      = (state_q == FETCH) || (state_q == EXEC);
    assign halted    = (state_q == HALTED);
    assign fault     = (state_q == FAULT);

endmodule
